// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration loader: FSM states,
// processing-mode encodings and default register-bank addresses.
package cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_CMP  = 3'd3,
        FINISH  = 3'd4
    } cfg_state_t;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_CONV   = 2'b10;

    localparam logic [4:0] DEF_MODE_ADDR = 5'h00;
    localparam logic [4:0] DEF_KERN_BASE = 5'h04;

endpackage

// File: rtl/cfg_loader.sv
// Programs the mode register and NUM_TAPS kernel taps into the processor bank.
// Define CFG_LOADER_READBACK_EN to verify every entry by readback after writing.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter logic [4:0] MODE_ADDR = DEF_MODE_ADDR,
    parameter logic [4:0] KERN_BASE = DEF_KERN_BASE,
    parameter int         NUM_TAPS  = 9
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [8*NUM_TAPS-1:0] kern,
    output logic                  reg_write_en,
    output logic [4:0]            reg_addr,
    output logic [7:0]            reg_wdata,
    input  logic [7:0]            reg_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4:0]            err_addr
);

    localparam int IW = $clog2(NUM_TAPS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TAPS);

`ifdef CFG_LOADER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    cfg_state_t            state_reg, state_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [1:0]            mode_reg, mode_next;
    logic [8*NUM_TAPS-1:0] kern_reg, kern_next;
    logic                  wen_reg, wen_next;
    logic [4:0]            addr_reg, addr_next;
    logic [7:0]            wdata_reg, wdata_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic [4:0]            err_addr_reg, err_addr_next;

    function automatic logic [4:0] entry_addr(input logic [IW-1:0] idx);
        return (idx == '0) ? MODE_ADDR : 5'(KERN_BASE + 5'(idx) - 5'd1);
    endfunction

    // Index 0 is the mode byte; index i selects tap i-1.
    function automatic logic [7:0] entry_data(input logic [IW-1:0] idx,
                                              input logic [1:0] m,
                                              input logic [8*NUM_TAPS-1:0] k);
        logic [7:0] d;
        d = {6'b0, m};
        for (int t = 0; t < NUM_TAPS; t++) begin
            if (idx == IW'(t + 1)) d = k[8*t +: 8];
        end
        return d;
    endfunction

    logic rd_mismatch;
    assign rd_mismatch = (reg_rdata != entry_data(idx_reg, mode_reg, kern_reg));

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        mode_next     = mode_reg;
        kern_next     = kern_reg;
        wen_next      = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        err_addr_next = err_addr_reg;

        if (state_reg != IDLE && abort) begin
            state_next = IDLE;
            idx_next   = '0;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_next    = WRITE;
                        idx_next      = '0;
                        mode_next     = mode;
                        kern_next     = kern;
                        wen_next      = 1'b1;
                        addr_next     = entry_addr('0);
                        wdata_next    = entry_data('0, mode, kern);
                        busy_next     = 1'b1;
                        err_next      = 1'b0;
                        err_addr_next = 5'd0;
                    end
                end
                WRITE: begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next = '0;
                        if (READBACK) begin
                            state_next = RD_ADDR;
                            addr_next  = entry_addr('0);
                        end else begin
                            state_next = FINISH;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        wen_next   = 1'b1;
                        addr_next  = entry_addr(idx_reg + 1'b1);
                        wdata_next = entry_data(idx_reg + 1'b1, mode_reg, kern_reg);
                    end
                end
                RD_ADDR: state_next = RD_CMP;
                RD_CMP: begin
                    // Only the first mismatch is recorded; readback carries on.
                    if (rd_mismatch && !err_reg) begin
                        err_next      = 1'b1;
                        err_addr_next = entry_addr(idx_reg);
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_next = FINISH;
                        idx_next   = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RD_ADDR;
                        idx_next   = idx_reg + 1'b1;
                        addr_next  = entry_addr(idx_reg + 1'b1);
                    end
                end
                FINISH: state_next = IDLE;
                default: begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            mode_reg     <= 2'b00;
            kern_reg     <= '0;
            wen_reg      <= 1'b0;
            addr_reg     <= 5'd0;
            wdata_reg    <= 8'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_addr_reg <= 5'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            mode_reg     <= mode_next;
            kern_reg     <= kern_next;
            wen_reg      <= wen_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            err_addr_reg <= err_addr_next;
        end
    end

    assign reg_write_en = wen_reg;
    assign reg_addr     = addr_reg;
    assign reg_wdata    = wdata_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    // Without readback the compare states are never entered, so the flags are constant 0.
    assign err          = READBACK & err_reg;
    assign err_addr     = READBACK ? err_addr_reg : 5'd0;

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader; expected writes are queued at start and
// popped as the DUT strobes reg_write_en. Handles both readback builds.
module tb_cfg_loader;
    import cfg_pkg::*;

    localparam int NT = 9;
`ifdef CFG_LOADER_READBACK_EN
    localparam bit RB  = 1'b1;
    localparam int LAT = 3*NT + 4;
    localparam int RST_AT = 12;
`else
    localparam bit RB  = 1'b0;
    localparam int LAT = NT + 2;
    localparam int RST_AT = 6;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic            abort;
    logic [1:0]      mode;
    logic [8*NT-1:0] kern;
    logic            reg_write_en;
    logic [4:0]      reg_addr;
    logic [7:0]      reg_wdata;
    logic [7:0]      reg_rdata;
    logic            busy;
    logic            done;
    logic            err;
    logic [4:0]      err_addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [4:0] addr; logic [7:0] data; } wr_t;
    wr_t sb_q[$];

    logic [7:0] mem [32];
    bit         corrupt_en = 1'b0;

    cfg_loader #(.MODE_ADDR(5'h00), .KERN_BASE(5'h04), .NUM_TAPS(NT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .mode(mode), .kern(kern), .reg_write_en(reg_write_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // Register-bank responder: stores writes, returns data one cycle after the address.
    always @(posedge clk) begin
        if (reg_write_en) mem[reg_addr] <= reg_wdata;
        if (corrupt_en && reg_addr == 5'h08)      reg_rdata <= 8'h05;
        else if (corrupt_en && reg_addr == 5'h0A) reg_rdata <= 8'h01;
        else                                      reg_rdata <= mem[reg_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_expected(input logic [1:0] m, input logic [8*NT-1:0] k);
        wr_t w;
        w.addr = 5'h00;
        w.data = {6'b0, m};
        sb_q.push_back(w);
        for (int i = 0; i < NT; i++) begin
            w.addr = 5'(5'h04 + i);
            w.data = 8'(k >> (8*i));
            sb_q.push_back(w);
        end
    endtask

    // Drives one load and checks every cycle until done (or abort recovery).
    task automatic run_load(input logic [1:0] m, input logic [8*NT-1:0] k,
                            input bit repulse, input bit exp_err,
                            input logic [4:0] exp_ea, input int abort_at);
        wr_t w;
        bit  finished;
        finished = 1'b0;
        start = 1'b1; mode = m; kern = k;
        push_expected(m, k);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= LAT + 2 && !finished; c++) begin
            if (abort_at != 0 && c == abort_at + 1) begin
                abort = 1'b0;
                check_val("abort_wen", 32'(reg_write_en), 32'd0);
                check_val("abort_busy", 32'(busy), 32'd0);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check_val("abort_nodone", 32'(done), 32'd0);
                    check_val("abort_nowr", 32'(reg_write_en), 32'd0);
                end
                sb_q.delete();
                return;
            end
            check_val("wen", 32'(reg_write_en), 32'(c <= NT + 1));
            if (reg_write_en) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    w = sb_q.pop_front();
                    $display("write cycle %0d: %02h <= %02h", c, reg_addr, reg_wdata);
                    check_val("waddr", 32'(reg_addr), 32'(w.addr));
                    check_val("wdata", 32'(reg_wdata), 32'(w.data));
                end
            end
            check_val("busy", 32'(busy), 32'(c < LAT));
            check_val("done", 32'(done), 32'(c == LAT));
            if (c == 1) check_val("err_clear", 32'(err), 32'd0);
            if (c == abort_at) abort = 1'b1;
            if (repulse && c == 3) begin
                start = 1'b1; mode = MODE_BYPASS; kern = {NT{8'h5A}};
            end
            if (repulse && c == 4) start = 1'b0;
            if (c == LAT) finished = 1'b1;
            else @(negedge clk);
        end
        check_val("timeout", 32'(finished), 32'd1);
        check_val("err", 32'(err), 32'(exp_err & RB));
        check_val("err_addr", 32'(err_addr), RB ? 32'(exp_ea) : 32'd0);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("load mode=%0d done at cycle %0d err=%0d err_addr=%02h", m, LAT, err, err_addr);
        @(negedge clk);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("hold_addr", 32'(reg_addr), 32'h0C);
        check_val("hold_wdata", 32'(reg_wdata), 32'(8'(k >> (8*(NT-1)))));
    endtask

    initial begin
        int taps [NT];
        logic [8*NT-1:0] k_lap;
        logic [8*NT-1:0] k_rnd;
        taps = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
        for (int i = 0; i < NT; i++) k_lap[8*i +: 8] = 8'(taps[i]);
        for (int i = 0; i < NT; i++) k_rnd[8*i +: 8] = 8'($urandom_range(0, 255));

        resetn = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; kern = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_wen", 32'(reg_write_en), 32'd0);
        check_val("rst_addr", 32'(reg_addr), 32'd0);
        check_val("rst_wdata", 32'(reg_wdata), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'({err, err_addr}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_load(MODE_CONV, k_lap, 1'b0, 1'b0, 5'h00, 0);
        run_load(MODE_INVERT, k_rnd, 1'b0, 1'b0, 5'h00, 0);
        corrupt_en = 1'b1;
        run_load(MODE_CONV, k_lap, 1'b0, 1'b1, 5'h08, 0);
        corrupt_en = 1'b0;
        run_load(MODE_CONV, k_lap, 1'b0, 1'b0, 5'h00, 5);
        run_load(MODE_CONV, k_lap, 1'b0, 1'b0, 5'h00, 0);
        run_load(MODE_INVERT, k_rnd, 1'b1, 1'b0, 5'h00, 0);

        // Abort and start together in IDLE: abort wins, nothing starts.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_val("abort_prio_busy", 32'(busy), 32'd0);
        check_val("abort_prio_wen", 32'(reg_write_en), 32'd0);

        // Reset in the middle of a load.
        start = 1'b1; mode = MODE_CONV; kern = k_lap;
        @(negedge clk);
        start = 1'b0;
        repeat (RST_AT - 1) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_val("mrst_wen", 32'(reg_write_en), 32'd0);
        check_val("mrst_addr", 32'(reg_addr), 32'd0);
        check_val("mrst_wdata", 32'(reg_wdata), 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_done", 32'(done), 32'd0);
        check_val("mrst_err", 32'({err, err_addr}), 32'd0);
        for (int j = 0; j < LAT; j++) begin
            @(negedge clk);
            check_val("mrst_quiet", 32'({reg_write_en, done, busy}), 32'd0);
        end
        $display("mid-load reset checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
